// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter unit.
package pc_pkg;

   typedef enum logic [2:0] {
      PC_SEQ,
      PC_HOLD,
      PC_BRANCH,
      PC_CALL,
      PC_RET,
      PC_TAILCALL,
      PC_TRAP
   } pc_sel_e;

   localparam logic [15:0] DEFAULT_RESET_VEC = 16'h0000;
   localparam logic [15:0] DEFAULT_TRAP_VEC  = 16'hFFF0;

   // Bits needed to hold an entry count in the range 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: one push, pop or top-replace per cycle.
// A push while full overwrites the oldest entry.
module ras_stack
   import pc_pkg::*;
#(
   parameter int unsigned AW    = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push,
   input  logic                        pop,
   input  logic                        replace,
   input  logic [AW-1:0]               data,
   output logic [AW-1:0]               top,
   output logic [cnt_width(DEPTH)-1:0] count,
   output logic                        empty,
   output logic                        full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = cnt_width(DEPTH);

   logic [AW-1:0] mem [DEPTH];
   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_next;
   logic [PW-1:0] top_idx;
   logic [CW-1:0] count_next;

   // ptr names the next free slot; when full it also names the oldest entry.
   assign top_idx = ptr - PW'(1);
   assign top     = mem[top_idx];

   always_comb begin
      ptr_next   = ptr;
      count_next = count;
      if (push) begin
         ptr_next = ptr + PW'(1);
         if (count != CW'(DEPTH)) begin
            count_next = count + CW'(1);
         end
      end else if (pop && (count != '0)) begin
         ptr_next   = ptr - PW'(1);
         count_next = count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr   <= '0;
         count <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         ptr   <= ptr_next;
         count <= count_next;
         empty <= (count_next == '0);
         full  <= (count_next == CW'(DEPTH));
      end
   end

   // Storage carries no reset; entries are only meaningful below count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (push) begin
            mem[ptr] <= data;
         end else if (replace && (count != '0)) begin
            mem[top_idx] <= data;
         end
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential advance, stall, branch, call/return
// via a return-address stack, and trap vectoring.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned    AW        = 16,
   parameter int unsigned    STEP      = 1,
   parameter logic [AW-1:0]  RESET_VEC = AW'(DEFAULT_RESET_VEC),
   parameter logic [AW-1:0]  TRAP_VEC  = AW'(DEFAULT_TRAP_VEC),
   parameter int unsigned    RAS_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            stall,
   input  logic                            branch_taken,
   input  logic                            call,
   input  logic                            ret,
   input  logic                            trap,
   input  logic [AW-1:0]                   branch_target,
   output logic [AW-1:0]                   pc_out,
   output logic [AW-1:0]                   pc_plus_step,
   output logic [cnt_width(RAS_DEPTH)-1:0] ras_count,
   output logic                            ras_empty,
   output logic                            ras_full,
   output logic                            ret_underflow
);

   pc_sel_e       sel;
   logic [AW-1:0] pc_next;
   logic [AW-1:0] ras_top;
   logic          ras_push;
   logic          ras_pop;
   logic          ras_replace;
   logic          underflow_next;

   assign pc_plus_step = pc_out + AW'(STEP);

   // Redirect priority: trap, then call/ret, then branch, then stall.
   always_comb begin
      sel = PC_SEQ;
      if (trap) begin
         sel = PC_TRAP;
      end else if (call && ret) begin
         sel = ras_empty ? PC_CALL : PC_TAILCALL;
      end else if (call) begin
         sel = PC_CALL;
      end else if (ret) begin
         sel = PC_RET;
      end else if (branch_taken) begin
         sel = PC_BRANCH;
      end else if (stall) begin
         sel = PC_HOLD;
      end
   end

   always_comb begin
      pc_next        = pc_plus_step;
      ras_push       = 1'b0;
      ras_pop        = 1'b0;
      ras_replace    = 1'b0;
      underflow_next = 1'b0;
      unique case (sel)
         PC_SEQ:      pc_next = pc_plus_step;
         PC_HOLD:     pc_next = pc_out;
         PC_BRANCH:   pc_next = branch_target;
         PC_TRAP:     pc_next = TRAP_VEC;
         PC_CALL: begin
            pc_next  = branch_target;
            ras_push = 1'b1;
         end
         PC_TAILCALL: begin
            pc_next     = branch_target;
            ras_replace = 1'b1;
         end
         PC_RET: begin
            // An empty stack falls back to the supplied target and flags it.
            if (ras_empty) begin
               pc_next        = branch_target;
               underflow_next = 1'b1;
            end else begin
               pc_next = ras_top;
               ras_pop = 1'b1;
            end
         end
         default:     pc_next = pc_plus_step;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_out        <= RESET_VEC;
         ret_underflow <= 1'b0;
      end else begin
         pc_out        <= pc_next;
         ret_underflow <= underflow_next;
      end
   end

   ras_stack #(
      .AW    (AW),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .reset   (reset),
      .push    (ras_push),
      .pop     (ras_pop),
      .replace (ras_replace),
      .data    (pc_plus_step),
      .top     (ras_top),
      .count   (ras_count),
      .empty   (ras_empty),
      .full    (ras_full)
   );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with hand-computed expected PC and RAS values.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic        trap = 1'b0;
   logic [15:0] branch_target = '0;
   logic [15:0] pc_out;
   logic [15:0] pc_plus_step;
   logic [2:0]  ras_count;
   logic        ras_empty;
   logic        ras_full;
   logic        ret_underflow;

   int n_checks = 0;
   int n_fail   = 0;

   pc_unit #(
      .AW        (16),
      .STEP      (1),
      .RESET_VEC (16'h0000),
      .TRAP_VEC  (16'hFFF0),
      .RAS_DEPTH (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .call          (call),
      .ret           (ret),
      .trap          (trap),
      .branch_target (branch_target),
      .pc_out        (pc_out),
      .pc_plus_step  (pc_plus_step),
      .ras_count     (ras_count),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .ret_underflow (ret_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 1'b0; branch_taken = 1'b0; call = 1'b0; ret = 1'b0; trap = 1'b0;
   endtask

   task automatic do_call(input logic [15:0] tgt);
      idle(); call = 1'b1; branch_target = tgt;
      step();
   endtask

   task automatic do_ret(input logic [15:0] tgt);
      idle(); ret = 1'b1; branch_target = tgt;
      step();
   endtask

   initial begin
      logic [15:0] exp_ret [4];
      exp_ret[0] = 16'h4001; exp_ret[1] = 16'h3001;
      exp_ret[2] = 16'h2001; exp_ret[3] = 16'h1001;

      // Reset state
      step(); step();
      check("rst_pc", 32'(pc_out), 32'h0);
      check("rst_cnt", 32'(ras_count), 32'h0);
      check("rst_empty", 32'(ras_empty), 32'h1);
      check("rst_full", 32'(ras_full), 32'h0);
      check("rst_uf", 32'(ret_underflow), 32'h0);
      reset = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         check($sformatf("seq_%0d", i), 32'(pc_out), 32'(i));
      end
      check("seq_empty", 32'(ras_empty), 32'h1);

      // Stall, then branch wins over stall
      idle(); branch_taken = 1'b1; branch_target = 16'h0010;
      step();
      check("br_10", 32'(pc_out), 32'h0010);
      idle(); stall = 1'b1;
      step(); check("stall_1", 32'(pc_out), 32'h0010);
      step(); check("stall_2", 32'(pc_out), 32'h0010);
      branch_taken = 1'b1; branch_target = 16'h0200;
      step(); check("br_over_stall", 32'(pc_out), 32'h0200);

      // Simple call / return
      idle(); branch_taken = 1'b1; branch_target = 16'h0020;
      step(); check("br_20", 32'(pc_out), 32'h0020);
      do_call(16'h0100);
      check("call_pc", 32'(pc_out), 32'h0100);
      check("call_cnt", 32'(ras_count), 32'h1);
      idle();
      step(); check("callee_1", 32'(pc_out), 32'h0101);
      step(); check("callee_2", 32'(pc_out), 32'h0102);
      do_ret(16'h0000);
      check("ret_pc", 32'(pc_out), 32'h0021);
      check("ret_cnt", 32'(ras_count), 32'h0);

      // Five calls overflow a depth-4 stack; oldest (0x0022) is lost
      do_call(16'h1000);
      do_call(16'h2000);
      do_call(16'h3000);
      do_call(16'h4000);
      check("full_cnt", 32'(ras_count), 32'h4);
      check("full_flag", 32'(ras_full), 32'h1);
      do_call(16'h5000);
      check("ovf_pc", 32'(pc_out), 32'h5000);
      check("ovf_cnt", 32'(ras_count), 32'h4);
      check("ovf_full", 32'(ras_full), 32'h1);
      for (int i = 0; i < 4; i++) begin
         do_ret(16'h0BAD);
         check($sformatf("pop_%0d", i), 32'(pc_out), 32'(exp_ret[i]));
         check($sformatf("pop_uf_%0d", i), 32'(ret_underflow), 32'h0);
      end
      check("pop_empty", 32'(ras_empty), 32'h1);
      do_ret(16'h0BAD);
      check("uf_pc", 32'(pc_out), 32'h0BAD);
      check("uf_pulse", 32'(ret_underflow), 32'h1);
      check("uf_cnt", 32'(ras_count), 32'h0);
      idle();
      step();
      check("uf_clear", 32'(ret_underflow), 32'h0);
      check("uf_next_pc", 32'(pc_out), 32'h0BAE);

      // Address wrap-around
      idle(); branch_taken = 1'b1; branch_target = 16'hFFFF;
      step();
      check("wrap_load", 32'(pc_out), 32'hFFFF);
      check("wrap_plus", 32'(pc_plus_step), 32'h0000);
      idle();
      step(); check("wrap_pc", 32'(pc_out), 32'h0000);

      // Trap beats call; tail call replaces top
      do_call(16'h0300);
      check("pre_trap_cnt", 32'(ras_count), 32'h1);
      idle(); trap = 1'b1; call = 1'b1; branch_target = 16'h0400;
      step();
      check("trap_pc", 32'(pc_out), 32'hFFF0);
      check("trap_cnt", 32'(ras_count), 32'h1);
      idle(); call = 1'b1; ret = 1'b1; branch_target = 16'h0500;
      step();
      check("tail_pc", 32'(pc_out), 32'h0500);
      check("tail_cnt", 32'(ras_count), 32'h1);
      do_ret(16'h0000);
      check("tail_ret_pc", 32'(pc_out), 32'hFFF1);
      check("tail_ret_cnt", 32'(ras_count), 32'h0);

      // Reset mid-stream with calls outstanding
      do_call(16'h0600);
      do_call(16'h0700);
      check("pre_rst_cnt", 32'(ras_count), 32'h2);
      idle(); ret = 1'b1; reset = 1'b1;
      step();
      check("mid_rst_pc", 32'(pc_out), 32'h0);
      check("mid_rst_cnt", 32'(ras_count), 32'h0);
      check("mid_rst_uf", 32'(ret_underflow), 32'h0);
      reset = 1'b0;
      do_ret(16'h0BAD);
      check("post_rst_pc", 32'(pc_out), 32'h0BAD);
      check("post_rst_uf", 32'(ret_underflow), 32'h1);
      idle();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
